// File: rtl/canvas_cmd_gen_if.sv
// Request and command-port bundle between the bus-side requester and canvas_cmd_gen.
// master drives requests and hold; slave is the command generator.
interface canvas_cmd_gen_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [1:0]  i_req_op;
   logic [8:0]  i_req_col;
   logic [7:0]  i_req_row;
   logic [9:0]  i_req_width;
   logic [8:0]  i_req_height;
   logic [7:0]  i_req_color;
   logic [9:0]  i_req_scroll;
   logic        i_hold;
   logic        o_cmd_clk;
   logic [31:0] o_cmd_data;
   logic        o_busy;
   logic        o_err;

   modport master (
      output i_req_valid, i_req_op, i_req_col, i_req_row, i_req_width,
             i_req_height, i_req_color, i_req_scroll, i_hold,
      input  o_req_ready, o_cmd_clk, o_cmd_data, o_busy, o_err
   );

   modport slave (
      input  i_req_valid, i_req_op, i_req_col, i_req_row, i_req_width,
             i_req_height, i_req_color, i_req_scroll, i_hold,
      output o_req_ready, o_cmd_clk, o_cmd_data, o_busy, o_err
   );
endinterface

// File: rtl/canvas_cmd_gen.sv
// Canvas command writer: expands fill/scroll requests into strobed 32-bit command words,
// two cycles per word (SETUP, STROBE); i_hold stretches SETUP only.
module canvas_cmd_gen #(
   parameter int FB_COLS = 512,
   parameter int FB_ROWS = 256
) (
   input  logic            i_clk,
   input  logic            i_rst,
   canvas_cmd_gen_if.slave bus
);
   localparam logic [9:0] COLS_W  = 10'(FB_COLS);
   localparam logic [8:0] ROWS_W  = 9'(FB_ROWS);
   localparam logic [1:0] OP_FILL = 2'd0;
   localparam logic [1:0] OP_SX   = 2'd1;
   localparam logic [1:0] OP_SY   = 2'd2;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_e;

   state_e      state_q, state_d;
   logic        is_fill_q, is_fill_d;
   logic [8:0]  base_col_q, base_col_d;
   logic [9:0]  width_q, width_d;
   logic [8:0]  height_q, height_d;
   logic [7:0]  color_q, color_d;
   logic [9:0]  c_q, c_d;
   logic [8:0]  r_q, r_d;
   logic [8:0]  col_q, col_d;
   logic [7:0]  row_q, row_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic [9:0]  col_inc;
   logic [8:0]  row_inc;
   logic [8:0]  col_nxt;
   logic [7:0]  row_nxt;
   logic        last_col, last_row, bad_org;

   function automatic logic [31:0] pix_word(input logic [8:0] col, input logic [7:0] row,
                                            input logic [7:0] color);
      return {4'h1, 3'b000, col, row, color};
   endfunction

   // Wide intermediates keep col+1 / row+1 from overflowing before the wrap subtract.
   always_comb begin
      col_inc  = {1'b0, col_q} + 10'd1;
      row_inc  = {1'b0, row_q} + 9'd1;
      col_nxt  = 9'((col_inc >= COLS_W) ? col_inc - COLS_W : col_inc);
      row_nxt  = 8'((row_inc >= ROWS_W) ? row_inc - ROWS_W : row_inc);
      last_col = (c_q + 10'd1) >= width_q;
      last_row = (r_q + 9'd1) >= height_q;
      bad_org  = ({1'b0, bus.i_req_col} >= COLS_W) || ({1'b0, bus.i_req_row} >= ROWS_W);
   end

   always_comb begin
      state_d    = state_q;
      is_fill_d  = is_fill_q;
      base_col_d = base_col_q;
      width_d    = width_q;
      height_d   = height_q;
      color_d    = color_q;
      c_d        = c_q;
      r_d        = r_q;
      col_d      = col_q;
      row_d      = row_q;
      data_d     = data_q;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.i_req_valid) begin
               case (bus.i_req_op)
                  OP_FILL: begin
                     if (bad_org) begin
                        err_d = 1'b1;
                     end else if (bus.i_req_width != 10'd0 && bus.i_req_height != 9'd0) begin
                        is_fill_d  = 1'b1;
                        base_col_d = bus.i_req_col;
                        width_d    = bus.i_req_width;
                        height_d   = bus.i_req_height;
                        color_d    = bus.i_req_color;
                        c_d        = 10'd0;
                        r_d        = 9'd0;
                        col_d      = bus.i_req_col;
                        row_d      = bus.i_req_row;
                        data_d     = pix_word(bus.i_req_col, bus.i_req_row, bus.i_req_color);
                        state_d    = SETUP;
                     end
                  end
                  OP_SX: begin
                     is_fill_d = 1'b0;
                     data_d    = {4'h2, 18'b0, bus.i_req_scroll};
                     state_d   = SETUP;
                  end
                  OP_SY: begin
                     is_fill_d = 1'b0;
                     data_d    = {4'h3, 19'b0, bus.i_req_scroll[8:0]};
                     state_d   = SETUP;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         SETUP: begin
            if (!bus.i_hold) begin
               state_d = STROBE;
            end
         end
         STROBE: begin
            if (is_fill_q && !(last_col && last_row)) begin
               if (!last_col) begin
                  c_d    = c_q + 10'd1;
                  col_d  = col_nxt;
                  data_d = pix_word(col_nxt, row_q, color_q);
               end else begin
                  c_d    = 10'd0;
                  r_d    = r_q + 9'd1;
                  col_d  = base_col_q;
                  row_d  = row_nxt;
                  data_d = pix_word(base_col_q, row_nxt, color_q);
               end
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         is_fill_q  <= 1'b0;
         base_col_q <= '0;
         width_q    <= '0;
         height_q   <= '0;
         color_q    <= '0;
         c_q        <= '0;
         r_q        <= '0;
         col_q      <= '0;
         row_q      <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_fill_q  <= is_fill_d;
         base_col_q <= base_col_d;
         width_q    <= width_d;
         height_q   <= height_d;
         color_q    <= color_d;
         c_q        <= c_d;
         r_q        <= r_d;
         col_q      <= col_d;
         row_q      <= row_d;
         data_q     <= data_d;
         err_q      <= err_d;
      end
   end

   // Strobe, ready and busy decode straight from state so reset clears them at once.
   assign bus.o_req_ready = (state_q == IDLE);
   assign bus.o_busy      = (state_q != IDLE);
   assign bus.o_cmd_clk   = (state_q == STROBE);
   assign bus.o_cmd_data  = data_q;
   assign bus.o_err       = err_q;
endmodule
